// File: rtl/fm_sb_seq.sv
// Spy buffer sequencer for one fast-monitoring RAM.
// The block has two jobs:
//   - Capture: it writes the monitored stream into the RAM, either free-running
//     or stopped by a freeze trigger plus a post-trigger word count.
//   - Playback: it reads stored words back, once or in a loop, through a
//     two-stage read pipeline (RAM output register, then output register).
module fm_sb_seq #(
  parameter int DATA_WIDTH    = 256,
  parameter int ADDR_WIDTH    = 10,
  parameter int PB_MODE_WIDTH = 2
) (
  input  logic                     i_spy_clock,
  input  logic                     i_spy_reset,
  input  logic [PB_MODE_WIDTH-1:0] i_pb_mode,
  input  logic                     i_freeze,
  input  logic                     i_freeze_trig,
  input  logic [ADDR_WIDTH-1:0]    i_post_trig_cnt,
  input  logic                     i_rearm,
  input  logic                     i_pb_start,
  input  logic [ADDR_WIDTH-1:0]    i_pb_len,
  input  logic [DATA_WIDTH-1:0]    i_in_data,
  input  logic                     i_in_vld,
  output logic                     o_mem_we,
  output logic [ADDR_WIDTH-1:0]    o_mem_waddr,
  output logic [DATA_WIDTH-1:0]    o_mem_wdata,
  output logic                     o_mem_re,
  output logic [ADDR_WIDTH-1:0]    o_mem_raddr,
  input  logic [DATA_WIDTH-1:0]    i_mem_rdata,
  output logic [DATA_WIDTH-1:0]    o_out_data,
  output logic                     o_out_vld,
  output logic [ADDR_WIDTH-1:0]    o_wr_ptr,
  output logic [ADDR_WIDTH-1:0]    o_trig_addr,
  output logic                     o_wrapped,
  output logic                     o_frozen,
  output logic                     o_pb_busy,
  output logic                     o_pb_done
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CAPTURE   = 3'd1;
  localparam logic [2:0] S_POST_TRIG = 3'd2;
  localparam logic [2:0] S_FROZEN    = 3'd3;
  localparam logic [2:0] S_PB_RUN    = 3'd4;

  localparam logic [PB_MODE_WIDTH-1:0] MODE_CAPTURE = PB_MODE_WIDTH'(2'd0);
  localparam logic [PB_MODE_WIDTH-1:0] MODE_PB_ONCE = PB_MODE_WIDTH'(2'd1);
  localparam logic [PB_MODE_WIDTH-1:0] MODE_PB_LOOP = PB_MODE_WIDTH'(2'd2);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = {ADDR_WIDTH{1'b1}};

  logic [2:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_trig_addr;
  logic [ADDR_WIDTH-1:0] r_post_cnt;
  logic                  r_wrapped;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH-1:0] r_pb_len;
  logic                  r_re_d1;
  logic                  r_last_d1;
  logic                  r_out_vld;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_pb_done;

  logic [2:0] w_next_state;
  logic       w_mode_cap;
  logic       w_mode_pb;
  logic       w_mode_once;
  logic       w_rearm;
  logic       w_we;
  logic       w_re;
  logic       w_rd_last;
  logic       w_trig_take;
  logic       w_pb_take;

  // Decode mode, qualify control pulses and form the RAM strobes.
  always_comb begin
    w_mode_cap  = (i_pb_mode == MODE_CAPTURE);
    w_mode_once = (i_pb_mode == MODE_PB_ONCE);
    w_mode_pb   = w_mode_once || (i_pb_mode == MODE_PB_LOOP);
    // Playback cannot be disturbed by rearm; everywhere else rearm wins.
    w_rearm     = i_rearm && (r_state != S_PB_RUN);
    // Freeze suppresses the write of the very cycle it is seen.
    w_we        = ((r_state == S_CAPTURE) || (r_state == S_POST_TRIG)) &&
                  i_in_vld && !i_freeze && !w_rearm;
    w_re        = (r_state == S_PB_RUN) && w_mode_pb;
    w_rd_last   = (r_rd_ptr == r_pb_len);
    w_trig_take = (r_state == S_CAPTURE) && !w_rearm && !i_freeze &&
                  w_mode_cap && i_freeze_trig;
    w_pb_take   = (((r_state == S_IDLE) && !w_mode_cap) || (r_state == S_FROZEN)) &&
                  !w_rearm && w_mode_pb && i_pb_start;
  end

  // Next-state selection for the capture/playback sequencer.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_rearm) begin
          w_next_state = w_mode_cap ? S_CAPTURE : S_IDLE;
        end else if (w_mode_cap) begin
          w_next_state = S_CAPTURE;
        end else if (w_pb_take) begin
          w_next_state = S_PB_RUN;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_CAPTURE: begin
        if (w_rearm) begin
          w_next_state = w_mode_cap ? S_CAPTURE : S_IDLE;
        end else if (i_freeze) begin
          w_next_state = S_FROZEN;
        end else if (!w_mode_cap) begin
          w_next_state = S_IDLE;
        end else if (w_trig_take) begin
          w_next_state = (i_post_trig_cnt == ADDR_ZERO) ? S_FROZEN : S_POST_TRIG;
        end else begin
          w_next_state = S_CAPTURE;
        end
      end
      S_POST_TRIG: begin
        if (w_rearm) begin
          w_next_state = w_mode_cap ? S_CAPTURE : S_IDLE;
        end else if (i_freeze || !w_mode_cap) begin
          w_next_state = S_FROZEN;
        end else if (w_we && (r_post_cnt == ADDR_ONE)) begin
          w_next_state = S_FROZEN;
        end else begin
          w_next_state = S_POST_TRIG;
        end
      end
      S_FROZEN: begin
        if (w_rearm) begin
          w_next_state = w_mode_cap ? S_CAPTURE : S_IDLE;
        end else if (w_pb_take) begin
          w_next_state = S_PB_RUN;
        end else begin
          w_next_state = S_FROZEN;
        end
      end
      S_PB_RUN: begin
        if (!w_mode_pb) begin
          w_next_state = S_IDLE;
        end else if (w_mode_once && w_rd_last) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_PB_RUN;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_spy_clock) begin
    if (i_spy_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Write pointer and sticky wrap flag; rearm clears both.
  always_ff @(posedge i_spy_clock) begin
    if (i_spy_reset) begin
      r_wr_ptr  <= ADDR_ZERO;
      r_wrapped <= 1'b0;
    end else if (w_rearm) begin
      r_wr_ptr  <= ADDR_ZERO;
      r_wrapped <= 1'b0;
    end else if (w_we) begin
      r_wr_ptr <= r_wr_ptr + ADDR_ONE;
      if (r_wr_ptr == ADDR_MAX) begin
        r_wrapped <= 1'b1;
      end else begin
        r_wrapped <= r_wrapped;
      end
    end else begin
      r_wr_ptr  <= r_wr_ptr;
      r_wrapped <= r_wrapped;
    end
  end

  // Trigger address capture and post-trigger countdown of written words.
  always_ff @(posedge i_spy_clock) begin
    if (i_spy_reset) begin
      r_trig_addr <= ADDR_ZERO;
      r_post_cnt  <= ADDR_ZERO;
    end else if (w_trig_take) begin
      r_trig_addr <= r_wr_ptr;
      r_post_cnt  <= i_post_trig_cnt;
    end else if ((r_state == S_POST_TRIG) && w_we) begin
      r_post_cnt <= r_post_cnt - ADDR_ONE;
    end else begin
      r_post_cnt <= r_post_cnt;
    end
  end

  // Playback read pointer; the length is latched when playback starts.
  always_ff @(posedge i_spy_clock) begin
    if (i_spy_reset) begin
      r_rd_ptr <= ADDR_ZERO;
      r_pb_len <= ADDR_ZERO;
    end else if (w_pb_take) begin
      r_rd_ptr <= ADDR_ZERO;
      r_pb_len <= i_pb_len;
    end else if (w_re) begin
      r_rd_ptr <= w_rd_last ? ADDR_ZERO : (r_rd_ptr + ADDR_ONE);
    end else begin
      r_rd_ptr <= r_rd_ptr;
    end
  end

  // Read pipeline: RAM data lands one cycle after mem_re, then is registered out.
  always_ff @(posedge i_spy_clock) begin
    if (i_spy_reset) begin
      r_re_d1    <= 1'b0;
      r_last_d1  <= 1'b0;
      r_out_vld  <= 1'b0;
      r_out_data <= {DATA_WIDTH{1'b0}};
      r_pb_done  <= 1'b0;
    end else begin
      r_re_d1   <= w_re;
      r_last_d1 <= w_re && w_mode_once && w_rd_last;
      r_out_vld <= r_re_d1;
      r_pb_done <= r_last_d1;
      if (r_re_d1) begin
        r_out_data <= i_mem_rdata;
      end else begin
        r_out_data <= r_out_data;
      end
    end
  end

  assign o_mem_we    = w_we;
  assign o_mem_waddr = r_wr_ptr;
  assign o_mem_wdata = w_we ? i_in_data : {DATA_WIDTH{1'b0}};
  assign o_mem_re    = w_re;
  assign o_mem_raddr = r_rd_ptr;
  assign o_out_data  = r_out_data;
  assign o_out_vld   = r_out_vld;
  assign o_wr_ptr    = r_wr_ptr;
  assign o_trig_addr = r_trig_addr;
  assign o_wrapped   = r_wrapped;
  assign o_frozen    = (r_state == S_FROZEN);
  assign o_pb_busy   = w_re || r_re_d1 || r_out_vld;
  assign o_pb_done   = r_pb_done;

endmodule

// File: tb/tb_fm_sb_seq.sv
// Directed bench for fm_sb_seq with a 16-entry RAM model attached.
module tb_fm_sb_seq;

  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk;
  logic          spy_reset;
  logic [1:0]    pb_mode;
  logic          freeze;
  logic          freeze_trig;
  logic [AW-1:0] post_trig_cnt;
  logic          rearm;
  logic          pb_start;
  logic [AW-1:0] pb_len;
  logic [DW-1:0] in_data;
  logic          in_vld;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          mem_re;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] out_data;
  logic          out_vld;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] trig_addr;
  logic          wrapped;
  logic          frozen;
  logic          pb_busy;
  logic          pb_done;

  int n_chk = 0;
  int n_err = 0;

  logic [DW-1:0] ram [0:(1<<AW)-1];

  fm_sb_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PB_MODE_WIDTH(2)) dut (
    .i_spy_clock(clk), .i_spy_reset(spy_reset), .i_pb_mode(pb_mode),
    .i_freeze(freeze), .i_freeze_trig(freeze_trig), .i_post_trig_cnt(post_trig_cnt),
    .i_rearm(rearm), .i_pb_start(pb_start), .i_pb_len(pb_len),
    .i_in_data(in_data), .i_in_vld(in_vld),
    .o_mem_we(mem_we), .o_mem_waddr(mem_waddr), .o_mem_wdata(mem_wdata),
    .o_mem_re(mem_re), .o_mem_raddr(mem_raddr), .i_mem_rdata(mem_rdata),
    .o_out_data(out_data), .o_out_vld(out_vld), .o_wr_ptr(wr_ptr),
    .o_trig_addr(trig_addr), .o_wrapped(wrapped), .o_frozen(frozen),
    .o_pb_busy(pb_busy), .o_pb_done(pb_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple dual-port RAM with a registered read port.
  always @(posedge clk) begin
    if (mem_we) ram[mem_waddr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_raddr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    spy_reset = 1'b1; pb_mode = 2'd3; freeze = 1'b0; freeze_trig = 1'b0;
    post_trig_cnt = 4'd0; rearm = 1'b0; pb_start = 1'b0; pb_len = 4'd0;
    in_data = 16'h0000; in_vld = 1'b0;
    tick(); tick();
    spy_reset = 1'b0;
    settle();
    chk("rst_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("rst_wrapped", 32'(wrapped), 32'd0);
    chk("rst_frozen", 32'(frozen), 32'd0);
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_pb_busy", 32'(pb_busy), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);

    // Free-running capture of five words
    pb_mode = 2'd0;
    tick();
    for (int i = 0; i < 5; i++) begin
      in_data = 16'h00A0 + 16'(i); in_vld = 1'b1;
      settle();
      chk("cap_we", 32'(mem_we), 32'd1);
      chk("cap_waddr", 32'(mem_waddr), 32'(i));
      chk("cap_wdata", 32'(mem_wdata), 32'h00A0 + 32'(i));
      tick();
    end
    in_vld = 1'b0;
    settle();
    chk("cap_wr_ptr5", 32'(wr_ptr), 32'd5);
    chk("cap_wrapped0", 32'(wrapped), 32'd0);
    chk("cap_out_vld0", 32'(out_vld), 32'd0);

    // Rearm, then 20 writes wrap the 16-entry buffer
    rearm = 1'b1;
    tick();
    rearm = 1'b0;
    settle();
    chk("rearm_wr_ptr", 32'(wr_ptr), 32'd0);
    for (int i = 0; i < 20; i++) begin
      in_data = 16'h0100 + 16'(i); in_vld = 1'b1;
      settle();
      chk("wrap_waddr", 32'(mem_waddr), 32'(i % 16));
      tick();
    end
    in_vld = 1'b0;
    settle();
    chk("wrap_wrapped", 32'(wrapped), 32'd1);
    chk("wrap_wr_ptr", 32'(wr_ptr), 32'd4);

    // Trigger at address 7 with three post-trigger words
    rearm = 1'b1;
    tick();
    rearm = 1'b0;
    settle();
    chk("rearm_wrapped", 32'(wrapped), 32'd0);
    for (int i = 0; i < 7; i++) begin
      in_data = 16'h0200 + 16'(i); in_vld = 1'b1;
      tick();
    end
    in_data = 16'h0207; freeze_trig = 1'b1; post_trig_cnt = 4'd3;
    settle();
    chk("trig_we", 32'(mem_we), 32'd1);
    chk("trig_waddr", 32'(mem_waddr), 32'd7);
    tick();
    freeze_trig = 1'b0;
    settle();
    chk("trig_addr", 32'(trig_addr), 32'd7);
    for (int i = 8; i < 11; i++) begin
      in_data = 16'h0200 + 16'(i);
      settle();
      chk("post_we", 32'(mem_we), 32'd1);
      chk("post_waddr", 32'(mem_waddr), 32'(i));
      chk("post_frozen", 32'(frozen), 32'd0);
      tick();
    end
    settle();
    chk("post_frozen1", 32'(frozen), 32'd1);
    chk("post_no_we", 32'(mem_we), 32'd0);
    chk("post_wr_ptr", 32'(wr_ptr), 32'd11);

    // Freeze and trigger together at address 2: freeze wins
    in_vld = 1'b0; rearm = 1'b1;
    tick();
    rearm = 1'b0;
    in_data = 16'h0300; in_vld = 1'b1;
    tick();
    in_data = 16'h0301;
    tick();
    in_data = 16'h0302; freeze = 1'b1; freeze_trig = 1'b1;
    settle();
    chk("frz_we", 32'(mem_we), 32'd0);
    tick();
    freeze = 1'b0; freeze_trig = 1'b0; in_vld = 1'b0;
    settle();
    chk("frz_frozen", 32'(frozen), 32'd1);
    chk("frz_trig_addr", 32'(trig_addr), 32'd7);
    chk("frz_wr_ptr", 32'(wr_ptr), 32'd2);

    // Single-pass playback of four words from FROZEN
    pb_mode = 2'd1; pb_len = 4'd3; pb_start = 1'b1;
    tick();
    pb_start = 1'b0; pb_len = 4'd9;
    settle();
    chk("pb1_frozen", 32'(frozen), 32'd0);
    chk("pb1_re0", 32'(mem_re), 32'd1);
    chk("pb1_raddr0", 32'(mem_raddr), 32'd0);
    chk("pb1_busy0", 32'(pb_busy), 32'd1);
    chk("pb1_vld0", 32'(out_vld), 32'd0);
    tick();
    chk("pb1_raddr1", 32'(mem_raddr), 32'd1);
    chk("pb1_vld1", 32'(out_vld), 32'd0);
    tick();
    chk("pb1_raddr2", 32'(mem_raddr), 32'd2);
    chk("pb1_vld2", 32'(out_vld), 32'd1);
    chk("pb1_data2", 32'(out_data), 32'h0300);
    chk("pb1_done2", 32'(pb_done), 32'd0);
    tick();
    chk("pb1_raddr3", 32'(mem_raddr), 32'd3);
    chk("pb1_data3", 32'(out_data), 32'h0301);
    tick();
    chk("pb1_re_off", 32'(mem_re), 32'd0);
    chk("pb1_vld4", 32'(out_vld), 32'd1);
    chk("pb1_data4", 32'(out_data), 32'h0202);
    chk("pb1_done4", 32'(pb_done), 32'd0);
    tick();
    chk("pb1_vld5", 32'(out_vld), 32'd1);
    chk("pb1_data5", 32'(out_data), 32'h0203);
    chk("pb1_done5", 32'(pb_done), 32'd1);
    chk("pb1_busy5", 32'(pb_busy), 32'd1);
    tick();
    chk("pb1_vld6", 32'(out_vld), 32'd0);
    chk("pb1_done6", 32'(pb_done), 32'd0);
    chk("pb1_busy6", 32'(pb_busy), 32'd0);
    chk("pb1_re6", 32'(mem_re), 32'd0);

    // Looped playback of two words, stopped by switching to hold
    pb_mode = 2'd2; pb_len = 4'd1; pb_start = 1'b1;
    tick();
    pb_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      settle();
      chk("pb2_re", 32'(mem_re), 32'd1);
      chk("pb2_raddr", 32'(mem_raddr), 32'(k % 2));
      chk("pb2_vld", 32'(out_vld), (k >= 2) ? 32'd1 : 32'd0);
      if (k >= 2) chk("pb2_data", 32'(out_data), (k % 2 == 0) ? 32'h0300 : 32'h0301);
      chk("pb2_done", 32'(pb_done), 32'd0);
      tick();
    end
    pb_mode = 2'd3;
    settle();
    chk("pb2_stop_re", 32'(mem_re), 32'd0);
    chk("pb2_tail0_vld", 32'(out_vld), 32'd1);
    chk("pb2_tail0_data", 32'(out_data), 32'h0300);
    chk("pb2_tail0_busy", 32'(pb_busy), 32'd1);
    tick();
    chk("pb2_tail1_vld", 32'(out_vld), 32'd1);
    chk("pb2_tail1_data", 32'(out_data), 32'h0301);
    chk("pb2_tail1_busy", 32'(pb_busy), 32'd1);
    chk("pb2_tail1_done", 32'(pb_done), 32'd0);
    tick();
    chk("pb2_end_vld", 32'(out_vld), 32'd0);
    chk("pb2_end_busy", 32'(pb_busy), 32'd0);
    chk("pb2_end_done", 32'(pb_done), 32'd0);
    chk("pb2_end_re", 32'(mem_re), 32'd0);

    // Reset in the middle of a playback clears in-flight data
    pb_mode = 2'd1; pb_len = 4'd5; pb_start = 1'b1;
    tick();
    pb_start = 1'b0;
    tick(); tick();
    chk("mid_vld", 32'(out_vld), 32'd1);
    chk("mid_data", 32'(out_data), 32'h0300);
    spy_reset = 1'b1;
    tick();
    chk("mid_rst_vld", 32'(out_vld), 32'd0);
    chk("mid_rst_busy", 32'(pb_busy), 32'd0);
    chk("mid_rst_re", 32'(mem_re), 32'd0);
    chk("mid_rst_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("mid_rst_trig", 32'(trig_addr), 32'd0);
    spy_reset = 1'b0; pb_mode = 2'd3;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
